// File: rtl/tri_csa_acc_pkg.sv
// Shared definitions for the carry-save accumulator.
//   - state_e     : resolve FSM state, 2-bit, accumulate state encoded as 0
//   - DefWidth    : default operand width
//   - DefAccWidth : default accumulator width
//   - ext_operand : sign/zero extension of an operand held in a wide container
package tri_csa_acc_pkg;

  localparam int unsigned DefWidth    = 32;
  localparam int unsigned DefAccWidth = 40;
  // Container width for ext_operand; accumulator widths must stay below this.
  localparam int unsigned MaxExtWidth = 128;

  typedef enum logic [1:0] {
    StAccum     = 2'd0,
    StResolveLo = 2'd1,
    StResolveHi = 2'd2,
    StDone      = 2'd3
  } state_e;

  // Extends the low w bits of v across the whole container. Mask arithmetic avoids a
  // variable bit-select, so the function stays width-clean for any w.
  function automatic logic [MaxExtWidth-1:0] ext_operand(input logic [MaxExtWidth-1:0] v,
                                                          input int unsigned           w,
                                                          input logic                  sgn);
    logic [MaxExtWidth-1:0] keep_mask;
    logic [MaxExtWidth-1:0] sign_mask;
    logic                   fill;
    sign_mask = MaxExtWidth'(1) << (w - 1);
    keep_mask = (MaxExtWidth'(1) << w) - MaxExtWidth'(1);
    fill      = sgn & (|(v & sign_mask));
    return (v & keep_mask) | ({MaxExtWidth{fill}} & ~keep_mask);
  endfunction

endpackage

// File: rtl/tri_csa_acc_row.sv
// One row of W 3:2 compressor bits.
// Ports:
//   x, y, z : three addends
//   sum     : bitwise sum
//   carry   : majority bits shifted left by one; the MSB carry is dropped (mod 2^W)
module tri_csa_acc_row
  import tri_csa_acc_pkg::*;
#(
  parameter int unsigned W = DefAccWidth
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic [W-1:0] z,
  output logic [W-1:0] sum,
  output logic [W-1:0] carry
);

  logic [W-1:0] maj;
  logic         unused_maj_msb;

  assign sum            = x ^ y ^ z;
  assign maj            = (x & y) | (x & z) | (y & z);
  assign carry          = {maj[W-2:0], 1'b0};
  assign unused_maj_msb = maj[W-1];

endmodule

// File: rtl/tri_csa_acc.sv
// Carry-save accumulator with on-demand carry-propagate readout.
// Each accepted beat folds ext(in_a) and ext(in_b) into the redundant S/C pair through two
// 3:2 rows. A resolve request adds S+C and returns the binary result over valid/ready.
// Build option: TRI_CSA_ACC_SPLIT_CPA_EN defined -> two-cycle split carry-propagate
// (RESOLVE_LO then RESOLVE_HI); undefined -> single full-width add in RESOLVE_LO.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   vd, gd              : power/ground pass-through, unused by logic
//   in_valid/in_ready   : operand beat handshake; in_a, in_b operands, in_signed extension mode
//   clear               : zero the accumulator (a coincident beat is loaded alone)
//   res_req, res_clr    : start resolve; res_clr clears the accumulator after the handshake
//   res_valid/res_ready : result handshake; res_data registered result
module tri_csa_acc
  import tri_csa_acc_pkg::*;
#(
  parameter int unsigned WIDTH     = DefWidth,
  parameter int unsigned ACC_WIDTH = DefAccWidth
) (
  input  logic                 clk,
  input  logic                 rst,
  inout  wire                  vd,
  inout  wire                  gd,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_b,
  input  logic                 in_signed,
  input  logic                 clear,
  input  logic                 res_req,
  input  logic                 res_clr,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [ACC_WIDTH-1:0] res_data
);

  state_e                 state_q, state_d;
  logic [ACC_WIDTH-1:0]   s_q, s_d, c_q, c_d;
  logic [ACC_WIDTH-1:0]   res_data_q, res_data_d;
  logic                   res_clr_q, res_clr_d;

  logic [MaxExtWidth-1:0] a_full, b_full;
  logic [ACC_WIDTH-1:0]   a_ext, b_ext;
  logic [ACC_WIDTH-1:0]   base_s, base_c, s1, c1, s2, c2;
  logic                   unused_rails, unused_ext;

  assign unused_rails = ^{vd, gd};

  assign a_full     = ext_operand(MaxExtWidth'(in_a), WIDTH, in_signed);
  assign b_full     = ext_operand(MaxExtWidth'(in_b), WIDTH, in_signed);
  assign a_ext      = a_full[ACC_WIDTH-1:0];
  assign b_ext      = b_full[ACC_WIDTH-1:0];
  assign unused_ext = ^{a_full[MaxExtWidth-1:ACC_WIDTH], b_full[MaxExtWidth-1:ACC_WIDTH]};

  // Clear feeds zeros into row 1, so clear plus a beat loads the beat alone.
  assign base_s = clear ? '0 : s_q;
  assign base_c = clear ? '0 : c_q;

  tri_csa_acc_row #(.W(ACC_WIDTH)) u_row1 (
    .x    (base_s),
    .y    (base_c),
    .z    (a_ext),
    .sum  (s1),
    .carry(c1)
  );

  tri_csa_acc_row #(.W(ACC_WIDTH)) u_row2 (
    .x    (s1),
    .y    (c1),
    .z    (b_ext),
    .sum  (s2),
    .carry(c2)
  );

  // S/C cannot change outside StAccum, so the resolve adders read them directly.
`ifdef TRI_CSA_ACC_SPLIT_CPA_EN
  localparam int unsigned LoW = (ACC_WIDTH + 1) / 2;
  localparam int unsigned HiW = ACC_WIDTH - LoW;

  logic [LoW:0]   lo_sum;
  logic [HiW-1:0] hi_sum;
  logic [LoW-1:0] lo_q;
  logic           cy_q;

  assign lo_sum = {1'b0, s_q[LoW-1:0]} + {1'b0, c_q[LoW-1:0]};
  assign hi_sum = s_q[ACC_WIDTH-1:LoW] + c_q[ACC_WIDTH-1:LoW] + HiW'(cy_q);

  always_ff @(posedge clk) begin
    if (state_q == StResolveLo) begin
      lo_q <= lo_sum[LoW-1:0];
      cy_q <= lo_sum[LoW];
    end
  end
`else
  logic [ACC_WIDTH-1:0] full_sum;
  assign full_sum = s_q + c_q;
`endif

  always_comb begin
    state_d    = state_q;
    s_d        = s_q;
    c_d        = c_q;
    res_clr_d  = res_clr_q;
    res_data_d = res_data_q;
    case (state_q)
      StAccum: begin
        if (clear) begin
          s_d = '0;
          c_d = '0;
        end
        if (in_valid) begin
          s_d = s2;
          c_d = c2;
        end
        if (res_req) begin
          state_d   = StResolveLo;
          res_clr_d = res_clr;
        end
      end
      StResolveLo: begin
`ifdef TRI_CSA_ACC_SPLIT_CPA_EN
        state_d    = StResolveHi;
`else
        res_data_d = full_sum;
        state_d    = StDone;
`endif
      end
      StResolveHi: begin
`ifdef TRI_CSA_ACC_SPLIT_CPA_EN
        res_data_d = {hi_sum, lo_q};
        state_d    = StDone;
`else
        state_d    = StAccum;
`endif
      end
      StDone: begin
        if (res_ready) begin
          state_d = StAccum;
          if (res_clr_q) begin
            s_d = '0;
            c_d = '0;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StAccum;
      s_q        <= '0;
      c_q        <= '0;
      res_clr_q  <= 1'b0;
      res_data_q <= '0;
    end else begin
      state_q    <= state_d;
      s_q        <= s_d;
      c_q        <= c_d;
      res_clr_q  <= res_clr_d;
      res_data_q <= res_data_d;
    end
  end

  assign in_ready  = (state_q == StAccum);
  assign res_valid = (state_q == StDone);
  assign res_data  = res_data_q;

endmodule

// File: tb/tb_tri_csa_acc.sv
module tb_tri_csa_acc;

  localparam int unsigned W  = 32;
  localparam int unsigned AW = 40;
`ifdef TRI_CSA_ACC_SPLIT_CPA_EN
  localparam int Lat = 3;
`else
  localparam int Lat = 2;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  wire           vd = 1'b1;
  wire           gd = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_signed = 1'b0;
  logic          clear = 1'b0;
  logic          res_req = 1'b0;
  logic          res_clr = 1'b0;
  logic          res_ready = 1'b0;
  logic [W-1:0]  in_a = '0;
  logic [W-1:0]  in_b = '0;
  logic          in_ready;
  logic          res_valid;
  logic [AW-1:0] res_data;

  int   checks = 0;
  int   failures = 0;
  logic cmp_en = 1'b0;

  always #5 clk = ~clk;

  tri_csa_acc #(
    .WIDTH    (W),
    .ACC_WIDTH(AW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .vd       (vd),
    .gd       (gd),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_a     (in_a),
    .in_b     (in_b),
    .in_signed(in_signed),
    .clear    (clear),
    .res_req  (res_req),
    .res_clr  (res_clr),
    .res_valid(res_valid),
    .res_ready(res_ready),
    .res_data (res_data)
  );

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Behavioural model: a plain binary accumulator plus a count of edges since the request.
  logic [AW-1:0] m_acc = '0;
  logic [AW-1:0] m_data = '0;
  logic          m_busy = 1'b0;
  logic          m_valid = 1'b0;
  logic          m_clr = 1'b0;
  int            m_cnt = 0;

  function automatic logic [AW-1:0] mext(input logic [W-1:0] v, input logic s);
    return {{(AW - W){s & v[W-1]}}, v};
  endfunction

  always @(posedge clk) begin
    logic [AW-1:0] nacc;
    if (rst) begin
      m_acc   <= '0;
      m_data  <= '0;
      m_busy  <= 1'b0;
      m_valid <= 1'b0;
      m_clr   <= 1'b0;
      m_cnt   <= 0;
    end else if (!m_busy) begin
      nacc = clear ? '0 : m_acc;
      if (in_valid) nacc = nacc + mext(in_a, in_signed) + mext(in_b, in_signed);
      m_acc <= nacc;
      if (res_req) begin
        m_busy <= 1'b1;
        m_cnt  <= 1;
        m_clr  <= res_clr;
      end
    end else if (!m_valid) begin
      m_cnt <= m_cnt + 1;
      if (m_cnt + 1 == Lat) begin
        m_valid <= 1'b1;
        m_data  <= m_acc;
      end
    end else if (res_ready) begin
      m_busy  <= 1'b0;
      m_valid <= 1'b0;
      if (m_clr) m_acc <= '0;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("cyc_in_ready", 64'(in_ready), 64'(!m_busy));
      check("cyc_res_valid", 64'(res_valid), 64'(m_valid));
      check("cyc_res_data", 64'(res_data), 64'(m_data));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    in_valid  = 1'b1;
    in_a      = a;
    in_b      = b;
    in_signed = s;
    cyc();
    in_valid  = 1'b0;
    in_signed = 1'b0;
    clear     = 1'b0;
  endtask

  // Drives a request (plus any beat/clear the caller set up) and waits for res_valid.
  task automatic resolve(input logic clr, input logic ready, output logic [AW-1:0] data,
                         output int lat);
    res_req   = 1'b1;
    res_clr   = clr;
    res_ready = ready;
    cyc();
    res_req  = 1'b0;
    res_clr  = 1'b0;
    in_valid = 1'b0;
    clear    = 1'b0;
    lat      = 1;
    while (!res_valid && lat < 12) begin
      cyc();
      lat++;
    end
    if (!res_valid) check("resolve_timeout", 64'(res_valid), 64'd1);
    data = res_data;
  endtask

  task automatic run_resolve(input string name, input logic clr, input logic [AW-1:0] exp);
    logic [AW-1:0] d;
    int            lat;
    resolve(clr, 1'b1, d, lat);
    check(name, 64'(d), 64'(exp));
    check({name, "_model"}, 64'(m_data), 64'(exp));
    check({name, "_latency"}, 64'(lat), 64'(Lat));
    cyc();
    check({name, "_ready_after"}, 64'(in_ready), 64'd1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [AW-1:0] d;
    int            lat;

    // Reset
    rst = 1'b1;
    cyc();
    cmp_en = 1'b1;
    cyc();
    rst = 1'b0;
    check("reset_in_ready", 64'(in_ready), 64'd1);
    check("reset_res_valid", 64'(res_valid), 64'd0);
    check("reset_res_data", 64'(res_data), 64'd0);

    // Mixed signedness: 5+7, then -1+3 -> 14
    beat(32'd5, 32'd7, 1'b0);
    beat(32'hFFFF_FFFF, 32'd3, 1'b1);
    run_resolve("mixed_sign", 1'b1, 40'h00_0000_000E);

    // Wrap: 256 * 2 * (2^32-1) mod 2^40
    for (int i = 0; i < 256; i++) beat(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    run_resolve("wrap", 1'b1, 40'hFF_FFFF_FE00);

    // Beat coincident with request on accumulator 100
    beat(32'd40, 32'd60, 1'b0);
    in_valid = 1'b1;
    in_a     = 32'd10;
    in_b     = 32'd20;
    run_resolve("coincident", 1'b1, 40'd130);

    // Backpressure: stall 5 cycles in DONE, with ignored beat/clear/request attempts
    beat(32'd9, 32'd9, 1'b0);
    resolve(1'b1, 1'b0, d, lat);
    check("bp_data", 64'(d), 64'd18);
    in_valid = 1'b1;
    in_a     = 32'd77;
    in_b     = 32'd77;
    clear    = 1'b1;
    res_req  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc();
      check("bp_valid_held", 64'(res_valid), 64'd1);
      check("bp_data_held", 64'(res_data), 64'd18);
      check("bp_in_ready_low", 64'(in_ready), 64'd0);
    end
    in_valid  = 1'b0;
    clear     = 1'b0;
    res_req   = 1'b0;
    res_ready = 1'b1;
    cyc();
    run_resolve("after_res_clr", 1'b0, 40'd0);

    // Clear coincident with beat on accumulator 1000
    beat(32'd500, 32'd500, 1'b0);
    clear = 1'b1;
    beat(32'd3, 32'd4, 1'b0);
    run_resolve("clear_with_beat", 1'b0, 40'd7);

    // Reset in the last resolve state
    beat(32'd1, 32'd2, 1'b0);
    res_req = 1'b1;
    cyc();
    res_req = 1'b0;
`ifdef TRI_CSA_ACC_SPLIT_CPA_EN
    cyc();
`endif
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    check("midreset_in_ready", 64'(in_ready), 64'd1);
    check("midreset_res_valid", 64'(res_valid), 64'd0);
    check("midreset_res_data", 64'(res_data), 64'd0);
    run_resolve("post_reset", 1'b0, 40'd0);

    // Randomized traffic, checked every cycle against the model
    for (int i = 0; i < 600; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_a      = $urandom;
      in_b      = $urandom;
      in_signed = 1'($urandom_range(0, 1));
      clear     = ($urandom_range(0, 15) == 0);
      res_req   = ($urandom_range(0, 7) == 0);
      res_clr   = 1'($urandom_range(0, 1));
      res_ready = ($urandom_range(0, 3) != 0);
      rst       = ($urandom_range(0, 149) == 0);
      cyc();
    end
    in_valid  = 1'b0;
    clear     = 1'b0;
    res_req   = 1'b0;
    res_ready = 1'b1;
    rst       = 1'b0;
    for (int i = 0; i < 6; i++) cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
